// File: rtl/flappy_pkg.sv
// Shared types and helpers for the 16x16 flappy LED game.
//   frame_t      : [row][col] bit frame driven onto the LED matrix
//   game_state_t : scroller FSM states
//   pipe_col     : one pipe column, every row lit except the gap
package flappy_pkg;
  localparam int GRID = 16;

  typedef logic [15:0][15:0] frame_t;
  typedef enum logic [1:0] {IDLE, RUN, FROZEN} game_state_t;

  // Bit r of the result is row r; rows top..top+gap-1 are left dark.
  function automatic logic [GRID-1:0] pipe_col(input logic [3:0] top, input int gap);
    logic [GRID-1:0] c;
    for (int r = 0; r < GRID; r++)
      c[r] = !((r >= int'(top)) && (r < int'(top) + gap));
    return c;
  endfunction
endpackage

// File: rtl/gap_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that picks pipe gap positions.
// Ports: clk, rst (sync, active-high, loads seed), adv (advance one step),
//        seed (reset value, must be nonzero), q (current state).
module gap_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;
endmodule

// File: rtl/pipe_scroller.sv
// Pipe obstacle generator for the 16x16 LED game. Injects a pipe with a
// random gap at column 0 every PIPE_SPACING steps, scrolls the frame one
// column toward 15 per step, scores each pipe leaving BIRD_COL, and freezes
// everything on gameover until rst.
// Ports: clk, rst (sync, active-high), start (IDLE->RUN), gameover (RUN->FROZEN),
//        RedPixels [row][col] frame, score (saturating), pipe_passed (1-cycle pulse).
// Build option: PIPE_SCROLLER_SPEEDUP_EN shortens the step period as score grows.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int         TICK_DIV     = 25_000_000,
  parameter int         GAP_H        = 4,
  parameter int         PIPE_SPACING = 6,
  parameter int         BIRD_COL     = 12,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gameover,
  output frame_t     RedPixels,
  output logic [7:0] score,
  output logic       pipe_passed
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(PIPE_SPACING);

  game_state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] sp_q, sp_d;
  // Stored column-major: cols_q[col][row], so a scroll is a whole-word shift.
  logic [GRID-1:0][GRID-1:0] cols_q, cols_d;
  logic [7:0] score_q, score_d;
  logic       pp_q, pp_d;
  logic       step;
  logic [7:0] lfsr_q;
  logic [3:0] top;
  logic [8:0] sum9;
  logic       unused_lfsr_hi;

  gap_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (step),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );
  assign unused_lfsr_hi = ^lfsr_q[7:4];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (gameover) state_d = FROZEN;
      FROZEN:  state_d = FROZEN;
      default: state_d = IDLE;
    endcase
  end

  // FSM: output (scroll step strobe)
`ifdef PIPE_SCROLLER_SPEEDUP_EN
  logic [1:0]  shamt;
  logic [31:0] period;
  always_comb begin
    shamt  = (score_q[7:3] >= 5'd3) ? 2'd3 : score_q[4:3];
    period = 32'(TICK_DIV) >> shamt;
    if (period == 32'd0) period = 32'd1;
    step = 1'b0;
    // >= rather than == so a period that just shrank still fires.
    if (state_q == RUN && !gameover) step = (32'(tick_q) >= period - 32'd1);
  end
`else
  always_comb begin
    step = 1'b0;
    if (state_q == RUN && !gameover) step = (tick_q == TW'(TICK_DIV - 1));
  end
`endif

  // Datapath next state
  always_comb begin
    tick_d  = tick_q;
    sp_d    = sp_q;
    cols_d  = cols_q;
    score_d = score_q;
    pp_d    = 1'b0;
    sum9    = {1'b0, score_q} + 9'd1;
    top     = lfsr_q[3:0];
    // Keep the whole gap on the grid.
    if (top > 4'(GRID - GAP_H)) top = top - 4'(GAP_H);

    if (state_q == RUN && !gameover) tick_d = step ? '0 : tick_q + 1'b1;

    if (step) begin
      for (int c = GRID - 1; c > 0; c--) cols_d[c] = cols_q[c-1];
      if (sp_q == '0) begin
        cols_d[0] = pipe_col(top, GAP_H);
        sp_d      = SW'(PIPE_SPACING - 1);
      end else begin
        cols_d[0] = '0;
        sp_d      = sp_q - 1'b1;
      end
      // Scored on the pre-shift frame: the pipe is leaving the bird column.
      if (|cols_q[BIRD_COL]) begin
        score_d = sum9[8] ? 8'hFF : sum9[7:0];
        pp_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      sp_q    <= '0;
      cols_q  <= '0;
      score_q <= '0;
      pp_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      sp_q    <= sp_d;
      cols_q  <= cols_d;
      score_q <= score_d;
      pp_q    <= pp_d;
    end
  end

  // Transpose to the [row][col] view the collision checker expects.
  always_comb begin
    RedPixels = '0;
    for (int r = 0; r < GRID; r++)
      for (int c = 0; c < GRID; c++)
        RedPixels[r][c] = cols_q[c][r];
  end

  assign score       = score_q;
  assign pipe_passed = pp_q;
endmodule

// File: tb/tb_pipe_scroller.sv
module tb_pipe_scroller;
  import flappy_pkg::*;

  localparam int TICK_DIV = 2, GAP_H = 4, PIPE_SPACING = 6, BIRD_COL = 12;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, gameover = 1'b0;
  frame_t     RedPixels;
  logic [7:0] score;
  logic       pipe_passed;

  pipe_scroller #(
    .TICK_DIV(TICK_DIV), .GAP_H(GAP_H), .PIPE_SPACING(PIPE_SPACING),
    .BIRD_COL(BIRD_COL), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .gameover(gameover),
    .RedPixels(RedPixels), .score(score), .pipe_passed(pipe_passed)
  );

  always #5 clk = ~clk;

  // Reference model, kept row-major (rows[r][c]) and stepped once per edge.
  typedef struct {
    frame_t     rows;
    int         score, state, tick, sp, steps, passes;
    logic [7:0] lfsr;
    logic       pp;
  } mst_t;

  typedef struct {
    frame_t     f;
    logic [7:0] sc;
    logic       pp;
  } exp_t;

  typedef struct {
    string       nm;
    int          steps;
    int          col;
    logic [15:0] cval;
    int          sc;
    int          pulses;
  } vec_t;

  mst_t ms;
  exp_t q[$];
  int   checks = 0, errors = 0, dut_pulses = 0;

  function automatic mst_t mstep(mst_t s, logic rs, logic st, logic go);
    mst_t n = s;
    int per, top;
    logic bird;
    logic [15:0] pc;
    n.pp = 1'b0;
    if (rs) begin
      n.rows = '0; n.score = 0; n.state = 0; n.tick = 0; n.sp = 0;
      n.steps = 0; n.passes = 0; n.lfsr = 8'hA5;
      return n;
    end
    case (s.state)
      0: if (st) n.state = 1;
      1: begin
        if (go) n.state = 2;
        else begin
          per = TICK_DIV;
`ifdef PIPE_SCROLLER_SPEEDUP_EN
          per = TICK_DIV >> (((s.score / 8) > 3) ? 3 : (s.score / 8));
          if (per < 1) per = 1;
`endif
          if (s.tick >= per - 1) begin
            n.tick = 0;
            n.steps = s.steps + 1;
            bird = 1'b0;
            for (int r = 0; r < 16; r++) if (s.rows[r][BIRD_COL]) bird = 1'b1;
            top = int'(s.lfsr[3:0]);
            if (top > 16 - GAP_H) top = top - GAP_H;
            for (int r = 0; r < 16; r++) begin
              pc[r] = (s.sp == 0) && !(r >= top && r < top + GAP_H);
              n.rows[r] = {s.rows[r][14:0], pc[r]};
            end
            n.sp = (s.sp == 0) ? PIPE_SPACING - 1 : s.sp - 1;
            n.lfsr = {s.lfsr[6:0], s.lfsr[7] ^ s.lfsr[5] ^ s.lfsr[4] ^ s.lfsr[3]};
            if (bird) begin
              n.score = (s.score >= 255) ? 255 : s.score + 1;
              n.pp = 1'b1;
              n.passes = s.passes + 1;
            end
          end else n.tick = s.tick + 1;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic exp_t expof(mst_t s);
    exp_t e;
    e.f = s.rows; e.sc = s.score[7:0]; e.pp = s.pp;
    return e;
  endfunction

  function automatic logic [15:0] colof(frame_t f, int c);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = f[r][c];
    return v;
  endfunction

  // Model: expectation pushed at the edge the inputs are applied.
  initial forever begin
    @(posedge clk);
    q.push_back(expof(mstep(ms, rst, start, gameover)));
    ms = mstep(ms, rst, start, gameover);
  end

  // Scoreboard: pop and compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      checks += 3;
      if (RedPixels !== q[0].f) begin
        errors++; $display("FAIL sb_frame t=%0t got %h exp %h", $time, RedPixels, q[0].f);
      end
      if (score !== q[0].sc) begin
        errors++; $display("FAIL sb_score t=%0t got %0d exp %0d", $time, score, q[0].sc);
      end
      if (pipe_passed !== q[0].pp) begin
        errors++; $display("FAIL sb_pulse t=%0t got %b exp %b", $time, pipe_passed, q[0].pp);
      end
      void'(q.pop_front());
    end
    if (pipe_passed === 1'b1) dut_pulses++;
  end

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic chkf(string nm, frame_t act, frame_t exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    checks++; errors++;
    $display("FAIL %s got timeout exp event", nm);
  endtask

  task automatic wait_steps(int target, int bound);
    int n = 0;
    while (ms.steps < target && n < bound) begin nxt(); n++; end
    if (ms.steps < target) timeout("wait_steps");
  endtask

  task automatic wait_tick(int t, int bound);
    int n = 0;
    while (ms.tick != t && n < bound) begin nxt(); n++; end
    if (ms.tick != t) timeout("wait_tick");
  endtask

  task automatic wait_score(int s, int bound);
    int n = 0;
    while (ms.score < s && n < bound) begin nxt(); n++; end
    if (ms.score < s) timeout("wait_score");
  endtask

  task automatic wait_passes(int p, int bound);
    int n = 0;
    while (ms.passes < p && n < bound) begin nxt(); n++; end
    if (ms.passes < p) timeout("wait_passes");
  endtask

  vec_t   tbl[8];
  frame_t fsnap;
  int     ssnap, p0, dp0;

  initial begin
    tbl[0] = '{"t3_col0_s1",    1,  0, 16'hFE1F, 0, 0};
    tbl[1] = '{"t3_col1_s2",    2,  1, 16'hFE1F, 0, 0};
    tbl[2] = '{"t3_col4_s5",    5,  4, 16'hFE1F, 0, 0};
    tbl[3] = '{"t3_col6_s7",    7,  6, 16'hFE1F, 0, 0};
    tbl[4] = '{"t3_newpipe_s7", 7,  0, 16'hFF87, 0, 0};
    tbl[5] = '{"t3_col12_s13", 13, 12, 16'hFE1F, 0, 0};
    tbl[6] = '{"t3_col13_s14", 14, 13, 16'hFE1F, 1, 1};
    tbl[7] = '{"t3_col7_s14",  14,  7, 16'hFF87, 1, 1};

    // 1: reset, then idle with start low
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    repeat (10) nxt();
    chkf("t1_frame", RedPixels, '0);
    chk("t1_score", 32'(score), 0);
    chk("t1_pulses", dut_pulses, 0);

    // 2: start; first step lands two edges after RUN entry
    start = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    chkf("t2_no_step_yet", RedPixels, '0);
    nxt();
    chk("t2_first_step", ms.steps, 1);
    begin
      frame_t f1 = '0;
      logic [15:0] c0 = 16'hFE1F;
      for (int r = 0; r < 16; r++) f1[r][0] = c0[r];
      chkf("t2_first_frame", RedPixels, f1);
    end

    // 3: scroll and scoring, table-driven
    for (int i = 0; i < 8; i++) begin
      wait_steps(tbl[i].steps, 100);
      chk({tbl[i].nm, "_col"}, 32'(colof(RedPixels, tbl[i].col)), 32'(tbl[i].cval));
      chk({tbl[i].nm, "_score"}, 32'(score), tbl[i].sc);
      chk({tbl[i].nm, "_pulses"}, dut_pulses, tbl[i].pulses);
    end

    // 4: gameover on a step cycle freezes everything
    wait_tick(TICK_DIV - 1, 10);
    fsnap = ms.rows;
    ssnap = ms.score;
    gameover = 1'b1;
    nxt();
    chkf("t4_no_shift", RedPixels, fsnap);
    gameover = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      nxt();
    end
    start = 1'b0;
    chkf("t4_frozen_frame", RedPixels, fsnap);
    chk("t4_frozen_score", 32'(score), ssnap);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chkf("t4_rst_frame", RedPixels, '0);
    chk("t4_rst_score", 32'(score), 0);
    repeat (6) nxt();
    chkf("t4_idle_frame", RedPixels, '0);

    // 5: score saturation
    start = 1'b1;
    nxt();
    start = 1'b0;
    wait_score(254, 8000);
    chk("t5_at_254", 32'(score), 254);
    p0  = ms.passes;
    dp0 = dut_pulses;
    wait_passes(p0 + 1, 100);
    chk("t5_255", 32'(score), 255);
    wait_passes(p0 + 2, 100);
    chk("t5_sat", 32'(score), 255);
    chk("t5_pulses", dut_pulses - dp0, 2);

    // 6: rst mid-RUN with tick=1
    wait_tick(1, 10);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chkf("t6_frame", RedPixels, '0);
    chk("t6_score", 32'(score), 0);
    chk("t6_pulse", 32'(pipe_passed), 0);
    repeat (3) nxt();
    chkf("t6_idle", RedPixels, '0);
    start = 1'b1;
    nxt();
    start = 1'b0;
    wait_steps(1, 20);
    chk("t6_reseeded_col0", 32'(colof(RedPixels, 0)), 32'h0000FE1F);

    repeat (3) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
